// File: rtl/pipelined_shifter_pkg.sv
// rtl/pipelined_shifter_pkg.sv - shift operation encoding and helpers shared by the shifter
package pipelined_shifter_pkg;

    typedef enum logic [2:0] {
        OP_SLL = 3'd0,
        OP_SRL = 3'd1,
        OP_SRA = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } shift_op_e;

    // Encodings 5..7 are reserved; the pipe passes the operand through and flags them.
    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= 3'd4;
    endfunction

endpackage

// File: rtl/pipelined_shifter_if.sv
// rtl/pipelined_shifter_if.sv - operand/result handshake bundle of the pipelined shifter
interface pipelined_shifter_if #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
);
    localparam int LOG2W = $clog2(WIDTH);

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic [LOG2W-1:0]  in_shamt;
    logic [2:0]        in_op;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;

    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err
    );

endinterface

// File: rtl/pipelined_shifter_shift_stage.sv
// rtl/pipelined_shifter_shift_stage.sv - one conditional power-of-two shift/rotate step
module shift_stage
    import pipelined_shifter_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SHAMT = 1
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic             sign,
    output logic [WIDTH-1:0] data_out
);

    // Shift or rotate by SHAMT when enabled; reserved ops and en=0 pass data through.
    always_comb begin
        data_out = data_in;
        if (en) begin
            case (op)
                OP_SLL:  data_out = {data_in[WIDTH-1-SHAMT:0], {SHAMT{1'b0}}};
                OP_SRL:  data_out = {{SHAMT{1'b0}}, data_in[WIDTH-1:SHAMT]};
                OP_SRA:  data_out = {{SHAMT{sign}}, data_in[WIDTH-1:SHAMT]};
                OP_ROL:  data_out = {data_in[WIDTH-1-SHAMT:0], data_in[WIDTH-1:WIDTH-SHAMT]};
                OP_ROR:  data_out = {data_in[SHAMT-1:0], data_in[WIDTH-1:SHAMT]};
                default: data_out = data_in;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_shifter.sv
// rtl/pipelined_shifter.sv - pipelined barrel shifter/rotator with valid/ready and tag
module pipelined_shifter
    import pipelined_shifter_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pipelined_shifter_if.slave bus
);

    localparam int LOG2W  = $clog2(WIDTH);
    localparam int NSLICE = (LOG2W + REG_EVERY - 1) / REG_EVERY;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [LOG2W-1:0] shamt;
        logic [2:0]       op;
        logic             sign;
        logic [TAG_W-1:0] tag;
    } slice_t;

    // head[g] feeds the group of stages in front of slice g: the raw input for
    // g=0, otherwise the contents of slice g-1.
    slice_t            head [NSLICE];
    logic [NSLICE-1:0] vld;
    logic [NSLICE-1:0] rdy;

    // SRA sign is latched at acceptance so intermediate stages never have to guess it.
    assign head[0] = '{data:  bus.in_data,
                       shamt: bus.in_shamt,
                       op:    bus.in_op,
                       sign:  bus.in_data[WIDTH-1],
                       tag:   bus.in_tag};

    assign bus.in_ready = rdy[0];

    // Back-pressure: a slice may load when it is empty or anything downstream can move.
    always_comb begin
        logic chain;
        chain = bus.out_ready;
        rdy   = '0;
        for (int j = NSLICE - 1; j >= 0; j--) begin
            chain  = chain | ~vld[j];
            rdy[j] = chain;
        end
    end

    for (genvar s = 0; s < LOG2W; s++) begin : g_stage
        localparam int G = s / REG_EVERY;
        logic [WIDTH-1:0] d_in;
        logic [WIDTH-1:0] d_out;

        if (s % REG_EVERY == 0) begin : g_head
            assign d_in = head[G].data;
        end else begin : g_chain
            assign d_in = g_stage[s-1].d_out;
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .SHAMT (1 << s)
        ) u_stage (
            .data_in  (d_in),
            .en       (head[G].shamt[s]),
            .op       (head[G].op),
            .sign     (head[G].sign),
            .data_out (d_out)
        );
    end

    for (genvar j = 0; j < NSLICE; j++) begin : g_slice
        localparam int LAST = ((j + 1) * REG_EVERY > LOG2W) ? LOG2W - 1 : (j + 1) * REG_EVERY - 1;
        logic   v;
        logic   src_valid;
        slice_t r;

        if (j == 0) begin : g_src_in
            assign src_valid = bus.in_valid;
        end else begin : g_src_prev
            assign src_valid = vld[j-1];
        end

        // Slice register: captures the shifted data plus the control that rides along.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v <= 1'b0;
                r <= '0;
            end else if (rdy[j]) begin
                v <= src_valid;
                r <= '{data:  g_stage[LAST].d_out,
                       shamt: head[j].shamt,
                       op:    head[j].op,
                       sign:  head[j].sign,
                       tag:   head[j].tag};
            end
        end

        assign vld[j] = v;

        if (j < NSLICE - 1) begin : g_fwd
            assign head[j+1] = r;
        end else begin : g_out
            logic unused_tail;
            assign unused_tail   = ^{r.shamt, r.sign};
            assign bus.out_valid = v;
            assign bus.out_data  = r.data;
            assign bus.out_tag   = r.tag;
            assign bus.out_err   = !is_legal_op(r.op);
        end
    end

endmodule

// File: tb/tb_pipelined_shifter.sv
// tb/tb_pipelined_shifter.sv - self-checking bench for pipelined_shifter (64/2 and 32/1)
module tb_pipelined_shifter;
    import pipelined_shifter_pkg::*;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_shifter_if #(.WIDTH(64), .TAG_W(4)) ia ();
    pipelined_shifter_if #(.WIDTH(32), .TAG_W(4)) ib ();

    pipelined_shifter #(.WIDTH(64), .REG_EVERY(2), .TAG_W(4)) dut_a (
        .clk (clk), .rst_n (rst_n), .bus (ia)
    );
    pipelined_shifter #(.WIDTH(32), .REG_EVERY(1), .TAG_W(4)) dut_b (
        .clk (clk), .rst_n (rst_n), .bus (ib)
    );

    exp_t        q_a[$];
    exp_t        q_b[$];
    exp_t        ea, eb;
    int          total = 0;
    int          bad = 0;
    logic [63:0] last_a, last_b;
    logic        last_err_a, last_err_b;
    logic [3:0]  last_tag_a;
    logic        hold_a = 1'b0, hold_b = 1'b0;
    logic [63:0] hd_a, hd_b;
    logic [3:0]  ht_a, ht_b;
    logic        sweep_done = 1'b0;
    logic        saw_full;

    function automatic logic [63:0] ref_shift(input int w, input logic [63:0] d,
                                              input int sh, input logic [2:0] op);
        logic [63:0] mask, x, r;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        x = d & mask;
        case (op)
            3'd0: r = (x << sh) & mask;
            3'd1: r = x >> sh;
            3'd2: begin
                r = x >> sh;
                if (x[w-1]) r = r | (mask & ~(mask >> sh));
            end
            3'd3: r = ((x << sh) | (x >> (w - sh))) & mask;
            3'd4: r = ((x >> sh) | (x << (w - sh))) & mask;
            default: r = x;
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_a(input logic [63:0] d, input int sh, input logic [2:0] op, input logic [3:0] tag);
        int n;
        exp_t e;
        ia.in_valid = 1'b1; ia.in_data = d; ia.in_shamt = sh[5:0]; ia.in_op = op; ia.in_tag = tag;
        n = 0;
        @(negedge clk);
        while (!ia.in_ready && n < 100) begin @(negedge clk); n++; end
        if (!ia.in_ready) chk("a_accept_timeout", 64'd0, 64'd1);
        else begin
            e.data = ref_shift(64, d, sh, op); e.tag = tag; e.err = (op > 3'd4);
            q_a.push_back(e);
        end
        @(posedge clk); #1;
        ia.in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [63:0] d, input int sh, input logic [2:0] op, input logic [3:0] tag);
        int n;
        exp_t e;
        ib.in_valid = 1'b1; ib.in_data = d[31:0]; ib.in_shamt = sh[4:0]; ib.in_op = op; ib.in_tag = tag;
        n = 0;
        @(negedge clk);
        while (!ib.in_ready && n < 100) begin @(negedge clk); n++; end
        if (!ib.in_ready) chk("b_accept_timeout", 64'd0, 64'd1);
        else begin
            e.data = ref_shift(32, d, sh, op); e.tag = tag; e.err = (op > 3'd4);
            q_b.push_back(e);
        end
        @(posedge clk); #1;
        ib.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 1000) begin @(posedge clk); n++; end
        if (n >= 1000) chk("drain_timeout", 64'(q_a.size() + q_b.size()), 64'd0);
        #1;
    endtask

    // Cycles from the accepting edge until out_valid, called right after a send.
    task automatic latency_a(output int lat);
        lat = 1;
        forever begin
            @(negedge clk);
            if (ia.out_valid || lat > 50) break;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic latency_b(output int lat);
        lat = 1;
        forever begin
            @(negedge clk);
            if (ib.out_valid || lat > 50) break;
            @(posedge clk);
            lat++;
        end
    endtask

    // Compare process for the 64-bit pipe: scoreboard order plus stall stability.
    always @(negedge clk) begin
        if (!rst_n) hold_a = 1'b0;
        else begin
            if (hold_a) begin
                chk("a_stall_valid", 64'(ia.out_valid), 64'd1);
                chk("a_stall_data", ia.out_data, hd_a);
                chk("a_stall_tag", 64'(ia.out_tag), 64'(ht_a));
            end
            if (ia.out_valid && ia.out_ready) begin
                if (q_a.size() == 0) chk("a_unexpected_out_tag", 64'(ia.out_tag), 64'hFFFF);
                else begin
                    ea = q_a.pop_front();
                    chk("a_data", ia.out_data, ea.data);
                    chk("a_tag", 64'(ia.out_tag), 64'(ea.tag));
                    chk("a_err", 64'(ia.out_err), 64'(ea.err));
                    last_a = ia.out_data; last_err_a = ia.out_err; last_tag_a = ia.out_tag;
                end
            end
            hold_a = ia.out_valid && !ia.out_ready;
            hd_a = ia.out_data;
            ht_a = ia.out_tag;
        end
    end

    // Compare process for the 32-bit, one-stage-per-slice pipe.
    always @(negedge clk) begin
        if (!rst_n) hold_b = 1'b0;
        else begin
            if (hold_b) begin
                chk("b_stall_valid", 64'(ib.out_valid), 64'd1);
                chk("b_stall_data", 64'(ib.out_data), hd_b);
                chk("b_stall_tag", 64'(ib.out_tag), 64'(ht_b));
            end
            if (ib.out_valid && ib.out_ready) begin
                if (q_b.size() == 0) chk("b_unexpected_out_tag", 64'(ib.out_tag), 64'hFFFF);
                else begin
                    eb = q_b.pop_front();
                    chk("b_data", 64'(ib.out_data), eb.data);
                    chk("b_tag", 64'(ib.out_tag), 64'(eb.tag));
                    chk("b_err", 64'(ib.out_err), 64'(eb.err));
                    last_b = 64'(ib.out_data); last_err_b = ib.out_err;
                end
            end
            hold_b = ib.out_valid && !ib.out_ready;
            hd_b = 64'(ib.out_data);
            ht_b = ib.out_tag;
        end
    end

    initial begin
        int lat;
        logic [63:0] x;
        ia.in_valid = 0; ia.in_data = '0; ia.in_shamt = '0; ia.in_op = '0; ia.in_tag = '0; ia.out_ready = 1;
        ib.in_valid = 0; ib.in_data = '0; ib.in_shamt = '0; ib.in_op = '0; ib.in_tag = '0; ib.out_ready = 1;

        // Hand-computed values that pin the reference model.
        chk("lit_sra", ref_shift(64, 64'h8000_0000_0000_0000, 4, 3'd2), 64'hF800_0000_0000_0000);
        chk("lit_srl", ref_shift(64, 64'h8000_0000_0000_0000, 4, 3'd1), 64'h0800_0000_0000_0000);
        chk("lit_ror1", ref_shift(64, 64'h1, 1, 3'd4), 64'h8000_0000_0000_0000);
        chk("lit_rol1", ref_shift(64, 64'h8000_0000_0000_0000, 1, 3'd3), 64'h1);
        chk("lit_rol63", ref_shift(64, 64'h0123_4567_89AB_CDEF, 63, 3'd3), 64'h8091_A2B3_C4D5_E6F7);
        chk("lit_ill", ref_shift(64, 64'h55AA, 9, 3'd7), 64'h55AA);
        chk("lit_sra32", ref_shift(32, 64'h8000_0010, 4, 3'd2), 64'hF800_0001);

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_a_out_valid", 64'(ia.out_valid), 64'd0);
        chk("rst_a_out_data", ia.out_data, 64'd0);
        chk("rst_a_out_tag", 64'(ia.out_tag), 64'd0);
        chk("rst_a_out_err", 64'(ia.out_err), 64'd0);
        chk("rst_a_in_ready", 64'(ia.in_ready), 64'd1);
        chk("rst_b_out_valid", 64'(ib.out_valid), 64'd0);
        chk("rst_b_in_ready", 64'(ib.in_ready), 64'd1);
        @(posedge clk); #1;

        // SRA/SRL with latency
        send_a(64'h8000_0000_0000_0000, 4, 3'd2, 4'd1);
        latency_a(lat);
        chk("t1_latency_a", 64'(lat), 64'd3);
        drain();
        chk("t1_sra_dut", last_a, 64'hF800_0000_0000_0000);
        send_a(64'h8000_0000_0000_0000, 4, 3'd1, 4'd2);
        drain();
        chk("t1_srl_dut", last_a, 64'h0800_0000_0000_0000);

        // Rotates
        send_a(64'h1, 1, 3'd4, 4'd3);
        drain();
        chk("t2_ror_dut", last_a, 64'h8000_0000_0000_0000);
        send_a(64'h8000_0000_0000_0000, 1, 3'd3, 4'd4);
        drain();
        chk("t2_rol_dut", last_a, 64'h1);
        send_a(64'h0123_4567_89AB_CDEF, 63, 3'd3, 4'd5);
        drain();
        chk("t2_rol63_dut", last_a, 64'h8091_A2B3_C4D5_E6F7);

        // shamt=0 is identity for every op
        for (int op = 0; op < 5; op++) begin
            send_a(64'hDEAD_BEEF_0123_4567, 0, op[2:0], 4'(op));
            drain();
            chk("t3_shamt0_data", last_a, 64'hDEAD_BEEF_0123_4567);
            chk("t3_shamt0_err", 64'(last_err_a), 64'd0);
        end

        // Illegal op
        send_a(64'h55AA, 5, 3'd7, 4'd6);
        drain();
        chk("t6_ill_data", last_a, 64'h55AA);
        chk("t6_ill_err", 64'(last_err_a), 64'd1);

        // Back-to-back with a downstream stall
        saw_full = 1'b0;
        fork
            begin
                for (int t = 0; t < 8; t++)
                    send_a(64'h0F0F_1234_8765_A5A5 ^ (64'd1 << (t * 8)), (t * 7) % 64, 3'(t % 5), 4'(t));
            end
            begin
                repeat (4) @(posedge clk);
                #1 ia.out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    if (!ia.in_ready) begin
                        saw_full = 1'b1;
                        chk("t4_full_occupancy", 64'(q_a.size()), 64'd3);
                    end
                    @(posedge clk);
                end
                #1 ia.out_ready = 1'b1;
            end
        join
        drain();
        chk("t4_saw_full", 64'(saw_full), 64'd1);
        chk("t4_last_tag", 64'(last_tag_a), 64'd7);

        // Reset with three ops held in the pipe
        ia.out_ready = 1'b0;
        send_a(64'h11, 1, 3'd0, 4'd8);
        send_a(64'h22, 2, 3'd1, 4'd9);
        send_a(64'h33, 3, 3'd3, 4'd10);
        rst_n = 1'b0;
        q_a.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t5_out_valid_after_rst", 64'(ia.out_valid), 64'd0);
        chk("t5_in_ready_after_rst", 64'(ia.in_ready), 64'd1);
        @(posedge clk); #1 ia.out_ready = 1'b1;
        send_a(64'h44, 4, 3'd4, 4'd11);
        drain();
        chk("t5_tag_after_rst", 64'(last_tag_a), 64'd11);

        // 32-bit, one stage per slice
        send_b(64'h1, 3, 3'd0, 4'd1);
        latency_b(lat);
        chk("t6_latency_b", 64'(lat), 64'd5);
        drain();
        chk("t6_sll_b", last_b, 64'h8);
        send_b(64'h55AA, 7, 3'd7, 4'd2);
        drain();
        chk("t6_ill_b_data", last_b, 64'h55AA);
        chk("t6_ill_b_err", 64'(last_err_b), 64'd1);

        fork
            begin
                for (int t = 0; t < 40; t++) begin
                    x = {32'd0, $urandom()};
                    send_b(x, $urandom_range(0, 31), 3'($urandom_range(0, 4)), 4'(t));
                end
                sweep_done = 1'b1;
            end
            begin
                while (!sweep_done) begin
                    @(posedge clk); #1;
                    ib.out_ready = 1'($urandom_range(0, 1));
                end
                ib.out_ready = 1'b1;
            end
        join
        drain();
        chk("sweep_b_drained", 64'(q_b.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
